// File: rtl/mode_req_arbiter.sv
// mode_req_arbiter: two-requester round-robin arbiter that applies a latched mode command and times out stuck grants
// Ports: clk, rst (sync, active-high) | req[1:0] level requests, cmd0/cmd1[2:0] mode commands
//        grant[1:0] one-hot grant, ack/err/to_err one-cycle pulses, mode[1:0] mode register, busy = FSM not idle
module mode_req_arbiter #(
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [2:0] cmd0,
    input  logic [2:0] cmd1,
    output logic [1:0] grant,
    output logic       ack,
    output logic       err,
    output logic       to_err,
    output logic [1:0] mode,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE = 2'b00, APPLY = 2'b01, RELEASE = 2'b10} state_t;
    logic [1:0] state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] mode_q, mode_d;
    logic [2:0] cmd_q, cmd_d;
    logic [7:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;
    logic       to_q, to_d;
    logic       busy_q, busy_d;
    logic       win;
    logic       gidx;
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        mode_d  = mode_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        to_d    = 1'b0;
        // with both requesting, serve whoever was not served last
        win     = (req == 2'b11) ? ~last_q : req[1];
        gidx    = grant_q[1];
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = win ? 2'b10 : 2'b01;
                    cmd_d   = win ? cmd1 : cmd0;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                ack_d   = 1'b1;
                cnt_d   = 8'd0;
                state_d = RELEASE;
                // LOCKED only accepts the LOCKED command itself, as a no-op
                err_d   = cmd_q[2] || (mode_q == 2'd3 && cmd_q != 3'd3);
                mode_d  = (!cmd_q[2] && mode_q != 2'd3) ? cmd_q[1:0] : mode_q;
            end
            RELEASE: begin
                if (!req[gidx] || cnt_q == 8'(TIMEOUT - 1)) begin
                    grant_d = 2'b00;
                    last_d  = gidx;
                    to_d    = req[gidx];
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                grant_d = 2'b00;
                err_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            mode_q  <= 2'd0;
            cmd_q   <= 3'd0;
            cnt_q   <= 8'd0;
            last_q  <= 1'b1;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            mode_q  <= mode_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            to_q    <= to_d;
            busy_q  <= busy_d;
        end
    end
    assign grant  = grant_q;
    assign ack    = ack_q;
    assign err    = err_q;
    assign to_err = to_q;
    assign mode   = mode_q;
    assign busy   = busy_q;
endmodule
